// File: rtl/hazard_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_pipeline_ctrl
//   Controls how the IF/ID and ID/EX pipeline registers of the 5-stage core
//   advance. Each cycle it decides whether the PC and IF/ID advance, hold or
//   flush, and whether ID/EX latches, holds or takes a bubble. It handles:
//     - load-use hazards, with a one-cycle bubble
//     - EX-stage redirects, which flush IF/ID for FLUSH_CYCLES cycles
//     - data-memory wait states, which freeze the whole pipe
//   It also keeps saturating counters of stall cycles and serviced redirects.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   id_rs1/id_rs2         source registers of the ID instruction
//   id_use_rs1/id_use_rs2 ID instruction really reads rs1 / rs2
//   id_control            decoder control bundle (MSB = enable)
//   ex_rd, ex_memread     destination register / load flag of the EX instr
//   ex_redirect           branch taken / jump resolved in EX
//   dmem_busy             data memory stalled; freeze everything
//   pc_write              PC may update
//   if_id_write           IF/ID may latch
//   if_id_flush           IF/ID loads a NOP
//   id_ex_write           ID/EX may latch
//   id_ex_control         ID/EX bundle; all zeros for a bubble
//   stall_cnt             cycles with pc_write=0 (saturating)
//   flush_cnt             redirects serviced (saturating)
// ---------------------------------------------------------------------------
module hazard_pipeline_ctrl #(
  parameter int REG_AW       = 5,
  parameter int CTRL_W       = 11,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [CTRL_W-1:0] id_control,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_redirect,
  input  logic              dmem_busy,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_write,
  output logic [CTRL_W-1:0] id_ex_control,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  // flush_left only ever holds values 0..FLUSH_CYCLES-1
  localparam int FLW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FLW-1:0] FL_RELOAD = FLW'(FLUSH_CYCLES - 1);
  // With a single flush cycle the redirect cycle is the whole window
  localparam state_t REDIR_NEXT = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;      // state to resume after MEM_WAIT
  logic [FLW-1:0]   flush_left_q, flush_left_d;
  logic             pend_q, pend_d;    // redirect seen while frozen
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             flush_inc;
  logic             load_use;
  state_t           eff_state;

  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((id_use_rs1 && (ex_rd == id_rs1)) ||
                     (id_use_rs2 && (ex_rd == id_rs2)));

  // Leaving MEM_WAIT, this cycle behaves as the state that was interrupted
  assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    flush_left_d  = flush_left_q;
    pend_d        = pend_q;
    flush_inc     = 1'b0;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_control = id_control;

    if (rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_control = '0;
      state_d       = RUN;
      ret_d         = RUN;
      flush_left_d  = '0;
      pend_d        = 1'b0;
    end else if (dmem_busy) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      id_ex_control = '0;
      if (state_q != MEM_WAIT) ret_d = state_q;
      state_d = MEM_WAIT;
      if (ex_redirect) pend_d = 1'b1;
    end else if (ex_redirect || pend_q) begin
      // pend_q can only be set while in MEM_WAIT
      if_id_flush   = 1'b1;
      id_ex_control = '0;
      flush_inc     = 1'b1;
      pend_d        = 1'b0;
      flush_left_d  = FL_RELOAD;
      state_d       = REDIR_NEXT;
    end else if (eff_state == FLUSH) begin
      if_id_flush   = 1'b1;
      id_ex_control = '0;
      flush_left_d  = flush_left_q - FLW'(1);
      state_d       = (flush_left_q == FLW'(1)) ? RUN : FLUSH;
    end else if (load_use) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_control = '0;
      state_d       = RUN;
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      ret_q        <= RUN;
      flush_left_q <= '0;
      pend_q       <= 1'b0;
      stall_q      <= '0;
      flush_q      <= '0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      flush_left_q <= flush_left_d;
      pend_q       <= pend_d;
      if (!pc_write && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_pipeline_ctrl.sv
module tb_hazard_pipeline_ctrl;
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_memread, ex_redirect, dmem_busy;
  logic [10:0] id_control;

  logic        pc_write, if_id_write, if_id_flush, id_ex_write;
  logic [10:0] id_ex_control;
  logic [15:0] stall_cnt, flush_cnt;
  logic        pc_write_s, if_id_write_s, if_id_flush_s, id_ex_write_s;
  logic [10:0] id_ex_control_s;
  logic [3:0]  stall_cnt_s, flush_cnt_s;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: remaining flush cycles, pending redirect, counters
  int  m_rem, m_stall, m_flush, m_stall_s, m_flush_s, n_rem;
  bit  m_pend, n_pend;
  logic e_pc, e_ifw, e_fl, e_idw, e_sinc, e_finc;
  logic [10:0] e_ctrl;

  always #5 clk = ~clk;

  hazard_pipeline_ctrl #(.REG_AW(5), .CTRL_W(11), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_control(id_control),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .dmem_busy(dmem_busy), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_write(id_ex_write),
    .id_ex_control(id_ex_control), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  hazard_pipeline_ctrl #(.REG_AW(5), .CTRL_W(11), .FLUSH_CYCLES(FC), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_control(id_control),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .dmem_busy(dmem_busy), .pc_write(pc_write_s), .if_id_write(if_id_write_s),
    .if_id_flush(if_id_flush_s), .id_ex_write(id_ex_write_s),
    .id_ex_control(id_ex_control_s), .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s));

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0;
    ex_redirect = 1'b0; dmem_busy = 1'b0;
    id_control = 11'($urandom);
  endtask

  task automatic set_load_use();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1; id_rs1 = 5'd7;
  endtask

  // Expected outputs for the current inputs, from the rules of the block
  task automatic model_eval();
    bit lu;
    lu = ex_memread && ex_rd != 0 &&
         ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    e_finc = 1'b0; n_rem = m_rem; n_pend = m_pend;
    if (rst) begin
      {e_pc, e_ifw, e_fl, e_idw} = 4'b0011; e_ctrl = '0; n_rem = 0; n_pend = 0;
    end else if (dmem_busy) begin
      {e_pc, e_ifw, e_fl, e_idw} = 4'b0000; e_ctrl = '0; n_pend = m_pend | ex_redirect;
    end else if (ex_redirect || m_pend) begin
      {e_pc, e_ifw, e_fl, e_idw} = 4'b1111; e_ctrl = '0; n_rem = FC - 1; n_pend = 0;
      e_finc = 1'b1;
    end else if (m_rem > 0) begin
      {e_pc, e_ifw, e_fl, e_idw} = 4'b1111; e_ctrl = '0; n_rem = m_rem - 1;
    end else if (lu) begin
      {e_pc, e_ifw, e_fl, e_idw} = 4'b0001; e_ctrl = '0;
    end else begin
      {e_pc, e_ifw, e_fl, e_idw} = 4'b1101; e_ctrl = id_control;
    end
    e_sinc = !rst && !e_pc;
  endtask

  task automatic settle();
    #4;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_rem = 0; m_pend = 0; m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    end else begin
      m_rem = n_rem; m_pend = n_pend;
      if (e_sinc) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall_s < 15) m_stall_s++;
      end
      if (e_finc) begin
        if (m_flush < 65535) m_flush++;
        if (m_flush_s < 15) m_flush_s++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); advance();
    for (int i = 0; i < 3; i++) begin
      idle(); settle();
      n_assert++;
      if ({pc_write, if_id_write, if_id_flush, id_ex_write} !== 4'b0011) begin
        n_fail++; $display("FAIL reset_flags: got %b want 0011", {pc_write, if_id_write, if_id_flush, id_ex_write});
      end
      n_assert++;
      if (id_ex_control !== 11'd0) begin
        n_fail++; $display("FAIL reset_ctrl: got %h want 0", id_ex_control);
      end
      n_assert++;
      if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
        n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
      end
      advance();
    end
    rst = 1'b0; idle(); settle();
    n_assert++;
    if (id_ex_control !== id_control || pc_write !== 1'b1) begin
      n_fail++; $display("FAIL reset_release: got ctrl %h pc %b want ctrl %h pc 1", id_ex_control, pc_write, id_control);
    end
    advance();
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    do_reset();
    idle(); set_load_use(); settle();
    n_assert++;
    if (pc_write !== 1'b0 || if_id_write !== 1'b0 || id_ex_write !== 1'b1 || id_ex_control !== 11'd0) begin
      n_fail++; $display("FAIL lu_bubble: got pc %b ifw %b idw %b ctrl %h want 0 0 1 0", pc_write, if_id_write, id_ex_write, id_ex_control);
    end
    advance();
    idle(); settle();
    n_assert++;
    if (pc_write !== 1'b1 || stall_cnt !== 16'd1) begin
      n_fail++; $display("FAIL lu_single: got pc %b stall %0d want pc 1 stall 1", pc_write, stall_cnt);
    end
    advance();
    idle(); ex_memread = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1; settle();
    n_assert++;
    if (pc_write !== 1'b1 || id_ex_control !== id_control) begin
      n_fail++; $display("FAIL lu_rd0: got pc %b ctrl %h want pc 1 ctrl %h", pc_write, id_ex_control, id_control);
    end
    advance();
    idle(); settle();
    n_assert++;
    if (stall_cnt !== 16'd1) begin
      n_fail++; $display("FAIL lu_rd0_cnt: got %0d want 1", stall_cnt);
    end
    advance();
    $display("test_load_use done");
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < FC; i++) begin
      idle(); ex_redirect = (i == 0); settle();
      n_assert++;
      if (if_id_flush !== 1'b1 || pc_write !== 1'b1 || id_ex_control !== 11'd0) begin
        n_fail++; $display("FAIL redir_flush%0d: got fl %b pc %b ctrl %h want 1 1 0", i, if_id_flush, pc_write, id_ex_control);
      end
      advance();
    end
    idle(); settle();
    n_assert++;
    if (if_id_flush !== 1'b0 || id_ex_control !== id_control || flush_cnt !== 16'd1) begin
      n_fail++; $display("FAIL redir_end: got fl %b ctrl %h cnt %0d want 0 %h 1", if_id_flush, id_ex_control, flush_cnt, id_control);
    end
    advance();
    $display("test_redirect done");
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle(); dmem_busy = 1'b1; ex_redirect = (i == 1); settle();
      n_assert++;
      if ({pc_write, if_id_write, if_id_flush, id_ex_write} !== 4'b0000) begin
        n_fail++; $display("FAIL mw_freeze%0d: got %b want 0000", i, {pc_write, if_id_write, if_id_flush, id_ex_write});
      end
      advance();
    end
    for (int i = 0; i < FC; i++) begin
      idle(); settle();
      n_assert++;
      if (if_id_flush !== 1'b1 || pc_write !== 1'b1 || id_ex_control !== 11'd0) begin
        n_fail++; $display("FAIL mw_flush%0d: got fl %b pc %b ctrl %h want 1 1 0", i, if_id_flush, pc_write, id_ex_control);
      end
      advance();
    end
    idle(); settle();
    n_assert++;
    if (if_id_flush !== 1'b0 || stall_cnt !== 16'd4 || flush_cnt !== 16'd1) begin
      n_fail++; $display("FAIL mw_end: got fl %b stall %0d flush %0d want 0 4 1", if_id_flush, stall_cnt, flush_cnt);
    end
    advance();
    $display("test_mem_wait done");
  endtask

  task automatic test_redir_lu();
    do_reset();
    idle(); set_load_use(); ex_redirect = 1'b1; settle();
    n_assert++;
    if (if_id_flush !== 1'b1 || pc_write !== 1'b1 || id_ex_control !== 11'd0) begin
      n_fail++; $display("FAIL rl_flush: got fl %b pc %b ctrl %h want 1 1 0", if_id_flush, pc_write, id_ex_control);
    end
    advance();
    idle(); set_load_use(); settle();
    n_assert++;
    if (pc_write !== 1'b1 || if_id_flush !== 1'b1 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rl_flush_ignores_lu: got pc %b fl %b stall %0d want 1 1 0", pc_write, if_id_flush, stall_cnt);
    end
    rst = 1'b1; advance();
    rst = 1'b0; idle(); settle();
    n_assert++;
    if (if_id_flush !== 1'b0 || pc_write !== 1'b1 || id_ex_control !== id_control || flush_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rl_rst_run: got fl %b pc %b ctrl %h fc %0d want 0 1 %h 0", if_id_flush, pc_write, id_ex_control, flush_cnt, id_control);
    end
    advance();
    $display("test_redir_lu done");
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      idle(); set_load_use(); settle();
      n_assert++;
      if (pc_write !== 1'b0 || pc_write_s !== 1'b0) begin
        n_fail++; $display("FAIL sat_stall%0d: got %b/%b want 0/0", i, pc_write, pc_write_s);
      end
      advance();
    end
    idle(); settle();
    n_assert++;
    if (stall_cnt_s !== 4'd15 || stall_cnt !== 16'd20) begin
      n_fail++; $display("FAIL sat_cnt: got %0d/%0d want 15/20", stall_cnt_s, stall_cnt);
    end
    advance();
    $display("test_saturation done");
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      idle();
      rst         = ($urandom_range(0, 59) == 0);
      dmem_busy   = ($urandom_range(0, 4) == 0);
      ex_redirect = ($urandom_range(0, 6) == 0);
      ex_memread  = ($urandom_range(0, 2) == 0);
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom);
      id_use_rs2  = 1'($urandom);
      settle();
      n_assert++;
      if ({pc_write, if_id_flush, id_ex_write} !== {e_pc, e_fl, e_idw} ||
          {pc_write_s, if_id_flush_s, id_ex_write_s} !== {e_pc, e_fl, e_idw}) begin
        n_fail++; $display("FAIL rnd_flags cyc %0d: got %b/%b want %b", i, {pc_write, if_id_flush, id_ex_write}, {pc_write_s, if_id_flush_s, id_ex_write_s}, {e_pc, e_fl, e_idw});
      end
      if (rst || !e_fl) begin
        n_assert++;
        if (if_id_write !== e_ifw || if_id_write_s !== e_ifw) begin
          n_fail++; $display("FAIL rnd_ifw cyc %0d: got %b/%b want %b", i, if_id_write, if_id_write_s, e_ifw);
        end
      end
      if (e_idw) begin
        n_assert++;
        if (id_ex_control !== e_ctrl || id_ex_control_s !== e_ctrl) begin
          n_fail++; $display("FAIL rnd_ctrl cyc %0d: got %h/%h want %h", i, id_ex_control, id_ex_control_s, e_ctrl);
        end
      end
      n_assert++;
      if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush) ||
          stall_cnt_s !== 4'(m_stall_s) || flush_cnt_s !== 4'(m_flush_s)) begin
        n_fail++; $display("FAIL rnd_cnt cyc %0d: got %0d %0d %0d %0d want %0d %0d %0d %0d", i, stall_cnt, flush_cnt, stall_cnt_s, flush_cnt_s, m_stall, m_flush, m_stall_s, m_flush_s);
      end
      advance();
    end
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b1;
    idle();
    m_rem = 0; m_pend = 0; m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    #1;
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_redir_lu();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
